instr_sequencer: RTL

Multi-cycle control FSM for the 16-bit lab CPU. It fetches instructions over a req/ack port, holds the current instruction stable for the combinational instruction decoder, and turns the decoder's `write`/`show` outputs into single, timed register-file write strobes and display handshakes. It sits between instruction memory, the decoder, the register file/ALU and the display driver. It provides run and single-step control and faults on illegal encodings.

---
 rtl/cpu_pkg.sv | 57 +++++
 rtl/instr_sequencer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 16-bit lab CPU: instruction field positions,
// legal opcodes, the sequencer state encoding and an instruction classifier.
// No ports (package).
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int INSTR_W   = 16;

    // Instruction field positions
    localparam int TYPE_BIT  = 15;
    localparam int OPC_MSB   = 14;
    localparam int OPC_LSB   = 6;
    localparam int ADDR1_MSB = 5;
    localparam int ADDR1_LSB = 3;
    localparam int ADDR2_MSB = 2;
    localparam int ADDR2_LSB = 0;

    // Legal 9-bit opcodes (only valid with the type bit clear)
    localparam logic [8:0] OP_NOP  = 9'b000000000;
    localparam logic [8:0] OP_ADD  = 9'b000000001;
    localparam logic [8:0] OP_SHOW = 9'b000010010;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_WB     = 3'd3,
        ST_SHOW   = 3'd4,
        ST_FAULT  = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        KIND_NOP     = 2'd0,
        KIND_ADD     = 2'd1,
        KIND_SHOW    = 2'd2,
        KIND_ILLEGAL = 2'd3
    } instr_kind_t;

    // Classify an instruction word; every type-bit-set encoding is illegal.
    function automatic instr_kind_t instr_kind(input logic [INSTR_W-1:0] instr);
        instr_kind_t kind;
        if (instr[TYPE_BIT]) begin
            kind = KIND_ILLEGAL;
        end else begin
            case (instr[OPC_MSB:OPC_LSB])
                OP_NOP:  kind = KIND_NOP;
                OP_ADD:  kind = KIND_ADD;
                OP_SHOW: kind = KIND_SHOW;
                default: kind = KIND_ILLEGAL;
            endcase
        end
        return kind;
    endfunction

endpackage

// File: rtl/instr_sequencer.sv
// -----------------------------------------------------------------------------
// instr_sequencer
// Multi-cycle control FSM of the lab CPU. Fetches instructions over a req/ack
// port, holds the current instruction for the external decoder, and converts
// the decoder's write/show indications into a one-cycle register-file write
// strobe and a display valid/ready handshake. Illegal encodings park the FSM
// in a sticky FAULT state that only rst_n leaves.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   run, step            continuous-run level, single-step pulse (IDLE only)
//   imem_req/addr/ack/data  instruction fetch port (addr = PC)
//   instr_q              latched instruction, feeds the decoder
//   dec_write, dec_show  decoder indications
//   rf_we                register-file write strobe
//   disp_valid/ready     display handshake
//   busy, fault          status (busy outside IDLE/FAULT; fault sticky)
//   retired              retired-instruction counter (wraps)
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module instr_sequencer
    import cpu_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}},
    parameter int              CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    input  logic               step,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] instr_q,
    input  logic               dec_write,
    input  logic               dec_show,
    output logic               rf_we,
    output logic               disp_valid,
    input  logic               disp_ready,
    output logic               busy,
    output logic               fault,
    output logic [CNT_W-1:0]   retired
);

    state_t             state_r,       state_nxt_s;
    logic [PC_W-1:0]    pc_r,          pc_nxt_s;
    logic [INSTR_W-1:0] instr_r,       instr_nxt_s;
    logic [CNT_W-1:0]   retired_r,     retired_nxt_s;
    logic               step_mode_r,   step_mode_nxt_s;
    logic               imem_req_r,    imem_req_nxt_s;
    logic               rf_we_r,       rf_we_nxt_s;
    logic               disp_valid_r,  disp_valid_nxt_s;
    logic               busy_r,        busy_nxt_s;
    logic               fault_r,       fault_nxt_s;
    logic               retire_s;
    instr_kind_t        kind_s;

    // Legality is judged on the latched word itself; dec_show carries the same
    // information and the address fields are the decoder's business, so they
    // are only collected here to document that they are intentionally unused.
    logic unused_s;
    assign unused_s = dec_show
                    ^ (^instr_r[ADDR1_MSB:ADDR1_LSB])
                    ^ (^instr_r[ADDR2_MSB:ADDR2_LSB]);

    assign kind_s = instr_kind(instr_r);

    // Next-state logic, datapath next values and next values of the output flops
    always_comb begin
        state_nxt_s     = state_r;
        pc_nxt_s        = pc_r;
        instr_nxt_s     = instr_r;
        retired_nxt_s   = retired_r;
        step_mode_nxt_s = step_mode_r;
        rf_we_nxt_s     = 1'b0;
        retire_s        = 1'b0;

        case (state_r)
            ST_IDLE: begin
                // run wins over step when both are present
                if (run) begin
                    state_nxt_s     = ST_FETCH;
                    step_mode_nxt_s = 1'b0;
                end else if (step) begin
                    state_nxt_s     = ST_FETCH;
                    step_mode_nxt_s = 1'b1;
                end else begin
                    state_nxt_s     = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    instr_nxt_s = imem_data;
                    state_nxt_s = ST_DECODE;
                end else begin
                    state_nxt_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                case (kind_s)
                    KIND_NOP: begin
                        retire_s = 1'b1;
                    end
                    KIND_ADD: begin
                        // Strobe is registered so it is high exactly during WB
                        state_nxt_s = ST_WB;
                        rf_we_nxt_s = dec_write;
                    end
                    KIND_SHOW: begin
                        state_nxt_s = ST_SHOW;
                    end
                    default: begin
                        state_nxt_s = ST_FAULT;
                    end
                endcase
            end
            ST_WB: begin
                retire_s = 1'b1;
            end
            ST_SHOW: begin
                if (disp_ready) begin
                    retire_s = 1'b1;
                end else begin
                    state_nxt_s = ST_SHOW;
                end
            end
            ST_FAULT: begin
                state_nxt_s = ST_FAULT;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase

        if (retire_s) begin
            pc_nxt_s      = pc_r + {{(PC_W-1){1'b0}}, 1'b1};
            retired_nxt_s = retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
            state_nxt_s   = (run && !step_mode_r) ? ST_FETCH : ST_IDLE;
        end else begin
            pc_nxt_s      = pc_r;
            retired_nxt_s = retired_r;
        end

        // Outputs are decoded from the next state and registered, so every
        // output is a flop with no path from any input.
        imem_req_nxt_s   = (state_nxt_s == ST_FETCH);
        disp_valid_nxt_s = (state_nxt_s == ST_SHOW);
        fault_nxt_s      = (state_nxt_s == ST_FAULT);
        busy_nxt_s       = (state_nxt_s != ST_IDLE) && (state_nxt_s != ST_FAULT);
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            pc_r         <= RESET_PC;
            instr_r      <= 16'h0000;
            retired_r    <= {CNT_W{1'b0}};
            step_mode_r  <= 1'b0;
            imem_req_r   <= 1'b0;
            rf_we_r      <= 1'b0;
            disp_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            fault_r      <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            pc_r         <= pc_nxt_s;
            instr_r      <= instr_nxt_s;
            retired_r    <= retired_nxt_s;
            step_mode_r  <= step_mode_nxt_s;
            imem_req_r   <= imem_req_nxt_s;
            rf_we_r      <= rf_we_nxt_s;
            disp_valid_r <= disp_valid_nxt_s;
            busy_r       <= busy_nxt_s;
            fault_r      <= fault_nxt_s;
        end
    end

    assign imem_req   = imem_req_r;
    assign imem_addr  = pc_r;
    assign instr_q    = instr_r;
    assign rf_we      = rf_we_r;
    assign disp_valid = disp_valid_r;
    assign busy       = busy_r;
    assign fault      = fault_r;
    assign retired    = retired_r;

endmodule
